// File: rtl/config_pkg.sv
// Shared definitions for the configuration dispatcher and the configuration
// register it drives.
//
// Contents:
//   - FSM state encodings (IDLE/ISSUE/WAIT/RESP) as constants and as an enum
//   - field offsets of the default {addr, flag, payload} message layout
//   - the packed message struct exchanged with the register
package config_pkg;

  localparam int ADDR_SIZE    = 4;
  localparam int PAYLOAD_SIZE = 8;
  localparam int MSG_W        = ADDR_SIZE + PAYLOAD_SIZE + 1;

  localparam int ADDR_MSB    = MSG_W - 1;
  localparam int ADDR_LSB    = PAYLOAD_SIZE + 1;
  localparam int FLAG_BIT    = PAYLOAD_SIZE;
  localparam int PAYLOAD_MSB = PAYLOAD_SIZE - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } state_e;

  // flag is "write" on requests, "success" on register replies and
  // "ack" on dispatcher responses.
  typedef struct packed {
    logic [ADDR_SIZE-1:0]    addr;
    logic                    flag;
    logic [PAYLOAD_SIZE-1:0] payload;
  } cfg_msg_t;

endpackage

// File: rtl/config_msg_dispatcher.sv
// Upstream stage of the configuration register. Takes config requests
// {addr, write, payload}, issues write requests to the register for one
// cycle, checks the register reply and returns one ack/nack per request.
// Only one request is in flight at a time.
//
// Optional feature (macro CFG_DISPATCH_TIMEOUT_EN):
//   defined   - WAIT may last up to timeout_cycles cycles (saturating counter)
//   undefined - WAIT lasts exactly one cycle, no counter
//
// Ports (W = addr_size + payload_size + 1):
//   clk       in   clock
//   reset     in   synchronous, active-high reset
//   recv_msg  in   W  request {addr, write, payload}
//   recv_val  in   request valid
//   recv_rdy  out  dispatcher can accept a request (IDLE)
//   cfg_msg   out  W  request to the register; zero unless issuing
//   cfg_resp  in   W  register reply {addr, success, payload}
//   send_msg  out  W  response {addr, ack, payload}
//   send_val  out  response valid
//   send_rdy  in   consumer accepts response
module config_msg_dispatcher
  import config_pkg::*;
#(
  parameter int addr_size      = 4,
  parameter int payload_size   = 8,
  parameter int timeout_cycles = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [addr_size+payload_size:0]       recv_msg,
  input  logic                                  recv_val,
  output logic                                  recv_rdy,
  output logic [addr_size+payload_size:0]       cfg_msg,
  input  logic [addr_size+payload_size:0]       cfg_resp,
  output logic [addr_size+payload_size:0]       send_msg,
  output logic                                  send_val,
  input  logic                                  send_rdy
);

  localparam int W    = addr_size + payload_size + 1;
  localparam int FLAG = payload_size;

  logic [1:0]   state_q;
  logic [W-1:0] req_q;
  logic         ack_q;
  logic         reply_match;
  logic         wait_expired;
  logic         wait_enter;

  // A reply matches when the register reports success for the exact
  // address/payload we issued.
  assign reply_match = cfg_resp[FLAG]
                    && (cfg_resp[W-1:FLAG+1] == req_q[W-1:FLAG+1])
                    && (cfg_resp[payload_size-1:0] == req_q[payload_size-1:0]);

  assign wait_enter = (state_q == ST_ISSUE);

`ifdef CFG_DISPATCH_TIMEOUT_EN
  localparam int CW = $clog2(timeout_cycles + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(timeout_cycles - 1);

  logic [CW-1:0] wait_cnt_q;

  // Cleared on the way into WAIT, counts WAIT cycles, saturates at the
  // last allowed cycle instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (wait_enter) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_WAIT && wait_cnt_q != CNT_LAST) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign wait_expired = (wait_cnt_q == CNT_LAST);
`else
  // Single-cycle WAIT: the reply window always closes after one cycle.
  // timeout_cycles is >= 1 by contract, so this is constant 1.
  localparam bit ONE_CYCLE_WAIT = (timeout_cycles >= 1);

  assign wait_expired = ONE_CYCLE_WAIT;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (recv_val) begin
            req_q <= recv_msg;
            ack_q <= 1'b0;
            // Reads are never issued to the register: nack immediately.
            state_q <= recv_msg[FLAG] ? ST_ISSUE : ST_RESP;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A match on the final cycle still wins over the timeout.
          if (reply_match) begin
            ack_q   <= 1'b1;
            state_q <= ST_RESP;
          end else if (wait_expired) begin
            ack_q   <= 1'b0;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (send_rdy) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign recv_rdy = (state_q == ST_IDLE);
  assign cfg_msg  = (state_q == ST_ISSUE) ? req_q : '0;
  assign send_val = (state_q == ST_RESP);
  assign send_msg = send_val ? {req_q[W-1:FLAG+1], ack_q, req_q[payload_size-1:0]} : '0;

endmodule
